// File: rtl/input_shift_register.sv
// Input shift register with MOV load, explicit/auto push and a 4-deep show-ahead RX FIFO.
// Request priority per cycle is mov_en > push_req > shift_en; stall means the request did not commit.
module input_shift_register (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        shift_en,
  input  logic [4:0]  shift_count,
  input  logic        shiftdir,
  input  logic        autopush,
  input  logic [4:0]  push_thresh,
  input  logic        push_req,
  input  logic        push_block,
  input  logic        push_iffull,
  input  logic [31:0] mov_in,
  input  logic        mov_en,
  input  logic        fifo_pop,
  output logic [31:0] isr,
  output logic [5:0]  input_shift_counter,
  output logic [31:0] fifo_data_out,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [2:0]  fifo_level,
  output logic        stall,
  output logic        pushed
);

  logic [31:0] isr_q, isr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [4];
  logic [1:0]  wptr_q, rptr_q;
  logic [2:0]  lvl_q;
  logic        pushed_q;

  logic [5:0]  n, thr, cnt_sh;
  logic [6:0]  sum;
  logic [31:0] mask, shifted, wdata;
  logic        room, wr, rd;

  assign n      = (shift_count == 5'd0) ? 6'd32 : {1'b0, shift_count};
  assign thr    = (push_thresh == 5'd0) ? 6'd32 : {1'b0, push_thresh};
  assign sum    = {1'b0, cnt_q} + {1'b0, n};
  assign cnt_sh = (sum > 7'd32) ? 6'd32 : sum[5:0];

  // n is never 0, so both shift amounts stay within 0..31 except the n=32 cases that clear isr.
  assign mask    = 32'hFFFF_FFFF >> (6'd32 - n);
  assign shifted = shiftdir ? ((isr_q >> n) | (in_data << (6'd32 - n)))
                            : ((isr_q << n) | (in_data & mask));

  assign fifo_full  = (lvl_q == 3'd4);
  assign fifo_empty = (lvl_q == 3'd0);
  assign room       = !fifo_full || fifo_pop;
  assign rd         = fifo_pop && !fifo_empty;

  always_comb begin
    isr_d = isr_q;
    cnt_d = cnt_q;
    wr    = 1'b0;
    wdata = 32'd0;
    stall = 1'b0;
    if (rst) begin
      if (mov_en) begin
        isr_d = mov_in;
        cnt_d = 6'd0;
      end else if (push_req) begin
        if (!(push_iffull && (cnt_q < thr))) begin
          if (room) begin
            wr    = 1'b1;
            wdata = isr_q;
            isr_d = 32'd0;
            cnt_d = 6'd0;
          end else if (push_block) begin
            stall = 1'b1;
          end else begin
            isr_d = 32'd0;
            cnt_d = 6'd0;
          end
        end
      end else if (shift_en) begin
        if (autopush && (cnt_sh >= thr)) begin
          if (room) begin
            wr    = 1'b1;
            wdata = shifted;
            isr_d = 32'd0;
            cnt_d = 6'd0;
          end else begin
            stall = 1'b1;
          end
        end else begin
          isr_d = shifted;
          cnt_d = cnt_sh;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      isr_q    <= 32'd0;
      cnt_q    <= 6'd0;
      wptr_q   <= 2'd0;
      rptr_q   <= 2'd0;
      lvl_q    <= 3'd0;
      pushed_q <= 1'b0;
    end else begin
      isr_q    <= isr_d;
      cnt_q    <= cnt_d;
      pushed_q <= wr;
      if (wr) wptr_q <= wptr_q + 2'd1;
      if (rd) rptr_q <= rptr_q + 2'd1;
      unique case ({wr, rd})
        2'b10:   lvl_q <= lvl_q + 3'd1;
        2'b01:   lvl_q <= lvl_q - 3'd1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst && wr) mem_q[wptr_q] <= wdata;
  end

  assign isr                 = isr_q;
  assign input_shift_counter = cnt_q;
  assign fifo_level          = lvl_q;
  assign fifo_data_out       = fifo_empty ? 32'd0 : mem_q[rptr_q];
  assign pushed              = pushed_q;

endmodule

// File: tb/tb_input_shift_register.sv
// Directed vector table plus randomized traffic, checked against a queue-based reference model.
module tb_input_shift_register;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data, mov_in;
  logic        shift_en, shiftdir, autopush, push_req, push_block, push_iffull, mov_en, fifo_pop;
  logic [4:0]  shift_count, push_thresh;
  logic [31:0] isr, fifo_data_out;
  logic [5:0]  input_shift_counter;
  logic        fifo_empty, fifo_full, stall, pushed;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  input_shift_register dut (
    .clk(clk), .rst(rst), .in_data(in_data), .shift_en(shift_en), .shift_count(shift_count),
    .shiftdir(shiftdir), .autopush(autopush), .push_thresh(push_thresh), .push_req(push_req),
    .push_block(push_block), .push_iffull(push_iffull), .mov_in(mov_in), .mov_en(mov_en),
    .fifo_pop(fifo_pop), .isr(isr), .input_shift_counter(input_shift_counter),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .stall(stall), .pushed(pushed)
  );

  typedef struct {
    bit r, sh; bit [4:0] sc; bit dir; bit [31:0] din; bit ap; bit [4:0] th;
    bit preq, pblk, piff, mov; bit [31:0] mv; bit pop;
    bit [31:0] e_isr; bit [5:0] e_cnt; bit [2:0] e_lvl; bit e_st; bit [31:0] e_head; bit e_push;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_isr;
  int          m_cnt;
  logic [31:0] m_q[$];
  bit          m_pushed;
  bit          m_stall;

  function automatic vec_t mk(bit r, bit sh, bit [4:0] sc, bit dir, bit [31:0] din, bit ap,
                              bit [4:0] th, bit preq, bit pblk, bit piff, bit mov, bit [31:0] mv,
                              bit pop, bit [31:0] eisr, bit [5:0] ecnt, bit [2:0] elvl, bit est,
                              bit [31:0] ehead, bit epush);
    vec_t v;
    v.r = r; v.sh = sh; v.sc = sc; v.dir = dir; v.din = din; v.ap = ap; v.th = th;
    v.preq = preq; v.pblk = pblk; v.piff = piff; v.mov = mov; v.mv = mv; v.pop = pop;
    v.e_isr = eisr; v.e_cnt = ecnt; v.e_lvl = elvl; v.e_st = est; v.e_head = ehead; v.e_push = epush;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] shift_bits(logic [31:0] cur, logic [31:0] din, int n, bit dir);
    logic [31:0] m = cur;
    if (dir) for (int i = 0; i < n; i++) m = {din[i], m[31:1]};
    else     for (int i = n - 1; i >= 0; i--) m = {m[30:0], din[i]};
    return m;
  endfunction

  task automatic model_step(input vec_t v);
    int n, t, cnt_new;
    bit room, wr;
    logic [31:0] wd, nv;
    n = (v.sc == 0) ? 32 : int'(v.sc);
    t = (v.th == 0) ? 32 : int'(v.th);
    room = (m_q.size() < 4) || v.pop;
    wr = 0; wd = 0; m_stall = 0;
    if (!v.r) begin
      m_isr = 0; m_cnt = 0; m_q.delete(); m_pushed = 0;
      return;
    end
    if (v.mov) begin
      m_isr = v.mv; m_cnt = 0;
    end else if (v.preq) begin
      if (!(v.piff && m_cnt < t)) begin
        if (room) begin wr = 1; wd = m_isr; m_isr = 0; m_cnt = 0; end
        else if (v.pblk) m_stall = 1;
        else begin m_isr = 0; m_cnt = 0; end
      end
    end else if (v.sh) begin
      nv = shift_bits(m_isr, v.din, n, v.dir);
      cnt_new = (m_cnt + n > 32) ? 32 : m_cnt + n;
      if (v.ap && cnt_new >= t) begin
        if (room) begin wr = 1; wd = nv; m_isr = 0; m_cnt = 0; end
        else m_stall = 1;
      end else begin
        m_isr = nv; m_cnt = cnt_new;
      end
    end
    if (v.pop && m_q.size() > 0) void'(m_q.pop_front());
    if (wr) m_q.push_back(wd);
    m_pushed = wr;
  endtask

  task automatic apply(input vec_t v, input bit use_exp, input int idx);
    logic [31:0] head;
    rst = v.r; shift_en = v.sh; shift_count = v.sc; shiftdir = v.dir; in_data = v.din;
    autopush = v.ap; push_thresh = v.th; push_req = v.preq; push_block = v.pblk;
    push_iffull = v.piff; mov_en = v.mov; mov_in = v.mv; fifo_pop = v.pop;
    #2;
    model_step(v);
    chk($sformatf("stall[%0d]", idx), 64'(stall), 64'(m_stall));
    if (use_exp) chk($sformatf("vec_stall[%0d]", idx), 64'(stall), 64'(v.e_st));
    @(posedge clk);
    #1;
    head = (m_q.size() > 0) ? m_q[0] : 32'd0;
    chk($sformatf("isr[%0d]", idx), 64'(isr), 64'(m_isr));
    chk($sformatf("cnt[%0d]", idx), 64'(input_shift_counter), 64'(m_cnt));
    chk($sformatf("level[%0d]", idx), 64'(fifo_level), 64'(m_q.size()));
    chk($sformatf("empty_full[%0d]", idx), 64'({fifo_empty, fifo_full}),
        64'({m_q.size() == 0, m_q.size() == 4}));
    chk($sformatf("head[%0d]", idx), 64'(fifo_data_out), 64'(head));
    chk($sformatf("pushed[%0d]", idx), 64'(pushed), 64'(m_pushed));
    if (use_exp) begin
      chk($sformatf("vec_isr[%0d]", idx), 64'(isr), 64'(v.e_isr));
      chk($sformatf("vec_cnt[%0d]", idx), 64'(input_shift_counter), 64'(v.e_cnt));
      chk($sformatf("vec_level[%0d]", idx), 64'(fifo_level), 64'(v.e_lvl));
      chk($sformatf("vec_head[%0d]", idx), 64'(fifo_data_out), 64'(v.e_head));
      chk($sformatf("vec_pushed[%0d]", idx), 64'(pushed), 64'(v.e_push));
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t rv;
    m_isr = 0; m_cnt = 0; m_pushed = 0; m_stall = 0;
    rst = 0; shift_en = 0; shift_count = 0; shiftdir = 0; in_data = 0; autopush = 0;
    push_thresh = 0; push_req = 0; push_block = 0; push_iffull = 0; mov_en = 0; mov_in = 0;
    fifo_pop = 0;
    @(posedge clk);
    #1;

    //             r sh sc dir din          ap th preq pblk piff mov mv           pop  e_isr        cnt lvl st head         push
    tbl.push_back(mk(0,0, 0,0,0,            0, 0, 0,0,0, 0,0,            0, 0,           0, 0,0, 0,           0));
    tbl.push_back(mk(1,1, 8,0,'hA5,         0, 0, 0,0,0, 0,0,            0, 'hA5,        8, 0,0, 0,           0));
    tbl.push_back(mk(1,0, 0,0,0,            0,16, 1,0,1, 0,0,            0, 'hA5,        8, 0,0, 0,           0));
    tbl.push_back(mk(1,1, 8,0,'h3C,         0, 0, 0,0,0, 0,0,            0, 'hA53C,     16, 0,0, 0,           0));
    tbl.push_back(mk(1,1, 0,1,'hDEADBEEF,   1, 0, 0,0,0, 0,0,            0, 0,           0, 1,0, 'hDEADBEEF,  1));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 0,0,0, 0,0,            0, 0,           0, 1,0, 'hDEADBEEF,  0));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 1,0,0, 0,0,            0, 0,           0, 2,0, 'hDEADBEEF,  1));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 1,0,0, 0,0,            0, 0,           0, 3,0, 'hDEADBEEF,  1));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 1,0,0, 0,0,            0, 0,           0, 4,0, 'hDEADBEEF,  1));
    tbl.push_back(mk(1,1,16,0,'h1234,       0, 0, 0,0,0, 0,0,            0, 'h1234,     16, 4,0, 'hDEADBEEF,  0));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 1,0,0, 0,0,            0, 0,           0, 4,0, 'hDEADBEEF,  0));
    tbl.push_back(mk(1,1,16,0,'hBEEF,       1, 0, 0,0,0, 0,0,            0, 'hBEEF,     16, 4,0, 'hDEADBEEF,  0));
    tbl.push_back(mk(1,1,16,0,'hCAFE,       1, 0, 0,0,0, 0,0,            0, 'hBEEF,     16, 4,1, 'hDEADBEEF,  0));
    tbl.push_back(mk(1,1,16,0,'hCAFE,       1, 0, 0,0,0, 0,0,            1, 0,           0, 4,0, 0,           1));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 1,1,0, 0,0,            0, 0,           0, 4,1, 0,           0));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 0,0,0, 0,0,            1, 0,           0, 3,0, 0,           0));
    tbl.push_back(mk(1,1, 8,0,'hFF,         0, 0, 0,0,0, 1,'hFFFF0000,   0, 'hFFFF0000,  0, 3,0, 0,           0));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 0,0,0, 0,0,            1, 'hFFFF0000,  0, 2,0, 0,           0));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 0,0,0, 0,0,            1, 'hFFFF0000,  0, 1,0, 'hBEEFCAFE,  0));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 1,0,0, 0,0,            0, 0,           0, 2,0, 'hBEEFCAFE,  1));
    tbl.push_back(mk(1,0, 0,0,0,            0, 0, 1,0,0, 0,0,            0, 0,           0, 3,0, 'hBEEFCAFE,  1));
    tbl.push_back(mk(0,0, 0,0,0,            0, 0, 1,0,0, 0,0,            0, 0,           0, 0,0, 0,           0));

    foreach (tbl[i]) apply(tbl[i], 1'b1, i);

    // Random traffic; rare resets and movs, frequent stalls via a slow consumer.
    for (int k = 0; k < 600; k++) begin
      rv = mk(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
              1'($urandom), $urandom, 1'($urandom), 5'($urandom_range(0, 31)),
              ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) == 0),
              0, 0, 0, 0, 0, 0);
      apply(rv, 1'b0, 100 + k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_shift_register.md
INPUT_SHIFT_REGISTER -- requirements
Module: input_shift_register

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-003 SHALL have: in_data  in  32  shift source (pin sample or scratch data).
REQ-004 SHALL have: shift_en  in  1  request IN shift this cycle; shift_count  in  5  bits to shift, 0 encodes 32; shiftdir  in  1  1=right (data enters MSB), 0=left (data enters LSB).
REQ-005 SHALL have: autopush  in  1  enable autopush; push_thresh  in  5  push threshold in bits, 0 encodes 32.
REQ-006 SHALL have: push_req  in  1  explicit PUSH; push_block  in  1  stall if FIFO full; push_iffull  in  1  push only if counter >= threshold.
REQ-007 SHALL have: mov_in  in  32  MOV source; mov_en  in  1  load ISR from mov_in.
REQ-008 SHALL have: fifo_pop  in  1  consumer pop of RX FIFO head.
REQ-009 SHALL have outputs: isr  32  shift register; input_shift_counter  6  bits held, 0..32; fifo_data_out  32  FIFO head (show-ahead); fifo_empty  1; fifo_full  1; fifo_level  3  entries, 0..4; stall  1  combinational, op not committed; pushed  1  registered one-cycle pulse after any FIFO write.

Function
REQ-010 SHALL decode n = shift_count==0 ? 32 : shift_count, and T = push_thresh==0 ? 32 : push_thresh.
REQ-011 Right shift SHALL yield (isr >> n) with in_data[n-1:0] placed in isr[31:32-n]; left shift SHALL yield (isr << n) with in_data[n-1:0] in isr[n-1:0]; n=32 SHALL yield isr = in_data for both directions.
REQ-012 Shift SHALL set counter to min(counter+n, 32) (saturating, 6-bit).
REQ-013 Priority per cycle SHALL be mov_en > push_req > shift_en; lower-priority requests in the same cycle are ignored (no stall from them).
REQ-014 mov_en SHALL load isr = mov_in and counter = 0; never stalls.
REQ-015 room SHALL be defined as (!fifo_full || fifo_pop).
REQ-016 Shift with autopush=1 and post-shift counter >= T: if room, SHALL write post-shift value to FIFO, set isr = 0 and counter = 0; if no room, SHALL assert stall and leave isr, counter and FIFO unchanged; the requester holds shift_en until stall drops.
REQ-017 Shift with autopush=0, or post-shift counter < T, SHALL commit the shift only; never stalls.
REQ-018 push_req with push_iffull=1 and counter < T SHALL be a no-op.
REQ-019 push_req otherwise: if room, SHALL write isr to FIFO and clear isr and counter; if no room and push_block=1, SHALL assert stall with no state change; if no room and push_block=0, SHALL drop the data and still clear isr and counter.
REQ-020 FIFO SHALL be 4 x 32, in-order; fifo_data_out SHALL equal head when non-empty and 0 when empty.
REQ-021 fifo_pop when empty SHALL be ignored; simultaneous write and pop SHALL keep level constant, including at level 4.
REQ-022 fifo_full = (level==4), fifo_empty = (level==0); pointers SHALL wrap modulo 4.
REQ-023 stall SHALL be 0 whenever no shift or push request is active.

Reset
REQ-024 While rst==0 at a clk edge: isr=0, counter=0, FIFO emptied (level 0, pointers 0), pushed=0; all requests that cycle ignored.
REQ-025 Reset mid-operation SHALL discard FIFO contents and any stalled request; stall SHALL read 0 while rst==0.

Verification
REQ-026 Left shift n=8 of 0xA5, then 0x3C, autopush=0 -> isr=0x0000A53C, counter=16.
REQ-027 Right shift n=0 (32) of 0xDEADBEEF, autopush=1, T=32 -> FIFO head 0xDEADBEEF, isr=0, counter=0, pushed pulses once.
REQ-028 Fill FIFO with 4 pushes, then autopush shift completing threshold -> stall=1, isr unchanged; pop same cycle -> stall=0, write commits, level stays 4.
REQ-029 push_req, push_block=0, FIFO full, isr=0x1234 -> no write, isr=0, counter=0, level 4; push_iffull=1 with counter 8 < T 16 -> no change.
REQ-030 mov_en with mov_in=0xFFFF0000 and simultaneous shift_en -> isr=0xFFFF0000, counter=0; rst=0 with 3 entries queued -> level 0, fifo_empty=1, fifo_data_out=0.
